// File: rtl/count_sequencer_if.sv
// count_sequencer_if: button inputs, monitored count and datapath control pins of the sweep controller.
interface count_sequencer_if #(
   parameter int WIDTH = 5
);
   logic             START;
   logic             STOP;
   logic [WIDTH-1:0] Q;
   logic             U_D;
   logic             M;
   logic             P_C;
   logic             BUSY;
   logic             DONE;
   logic [2:0]       STATE;
   modport master (output START, STOP, Q, input U_D, M, P_C, BUSY, DONE, STATE);
   modport slave  (input START, STOP, Q, output U_D, M, P_C, BUSY, DONE, STATE);
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: runs fast-up / hold / slow-down / hold sweeps on the counter datapath,
// watching the counter output Q to end each leg.
module count_sequencer #(
   parameter int WIDTH       = 5,
   parameter int HI_LIM      = 24,
   parameter int LO_LIM      = 3,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CYCLES      = 4
) (
   input logic              CLK50MHz,
   input logic              RST,
   count_sequencer_if.slave bus
);
   localparam int TW = $clog2(HOLD_CYCLES) + 1;
   localparam int CW = $clog2(CYCLES) + 1;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN_UP  = 3'd1,
      S_HOLD_HI = 3'd2,
      S_RUN_DN  = 3'd3,
      S_HOLD_LO = 3'd4,
      S_DONE    = 3'd5
   } state_t;
   state_t           state_q, state_d;
   logic [2:0]       start_q, stop_q;
   logic [WIDTH-1:0] q1_q, q2_q, qs_q;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic             u_d_q, u_d_d, m_q, m_d, p_c_q, p_c_d, busy_q, busy_d, done_q, done_d;
   logic             start_p, stop_p, hold_end;
   // bits [1:0] synchronize, bit 2 remembers the previous synchronized level
   assign start_p  = start_q[1] & ~start_q[2];
   assign stop_p   = stop_q[1] & ~stop_q[2];
   assign hold_end = tmr_q == TW'(HOLD_CYCLES - 1);
   always_ff @(posedge CLK50MHz) begin
      if (!RST) begin
         state_q <= S_IDLE;
         start_q <= '0;
         stop_q  <= '0;
         q1_q    <= '0;
         q2_q    <= '0;
         qs_q    <= '0;
         tmr_q   <= '0;
         cyc_q   <= '0;
         u_d_q   <= 1'b1;
         m_q     <= 1'b0;
         p_c_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= {start_q[1:0], bus.START};
         stop_q  <= {stop_q[1:0], bus.STOP};
         q1_q    <= bus.Q;
         q2_q    <= q1_q;
         // multi-bit crossing: accept Q only once two successive samples agree
         if (q1_q == q2_q) qs_q <= q2_q;
         tmr_q   <= tmr_d;
         cyc_q   <= cyc_d;
         u_d_q   <= u_d_d;
         m_q     <= m_d;
         p_c_q   <= p_c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_p) begin
               state_d = S_RUN_UP;
               cyc_d   = '0;
            end
         end
         S_RUN_UP:  if (qs_q >= WIDTH'(HI_LIM)) state_d = S_HOLD_HI;
         S_HOLD_HI: if (hold_end) state_d = S_RUN_DN;
         S_RUN_DN:  if (qs_q <= WIDTH'(LO_LIM)) state_d = S_HOLD_LO;
         S_HOLD_LO: begin
            if (hold_end) begin
               if (CYCLES != 0 && cyc_q == CW'(CYCLES - 1)) state_d = S_DONE;
               else begin
                  state_d = S_RUN_UP;
                  cyc_d   = cyc_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (stop_p) state_d = S_IDLE;
      tmr_d  = (state_d == state_q && (state_q == S_HOLD_HI || state_q == S_HOLD_LO)) ? tmr_q + 1'b1 : '0;
      u_d_d  = state_d == S_RUN_UP ? 1'b1 : state_d == S_RUN_DN ? 1'b0 : u_d_q;
      m_d    = state_d == S_RUN_UP ? 1'b1 : state_d == S_RUN_DN ? 1'b0 : m_q;
      p_c_d  = state_d == S_RUN_UP || state_d == S_RUN_DN;
      busy_d = state_d inside {S_RUN_UP, S_HOLD_HI, S_RUN_DN, S_HOLD_LO};
      done_d = state_d == S_DONE;
   end
   assign bus.U_D   = u_d_q;
   assign bus.M     = m_q;
   assign bus.P_C   = p_c_q;
   assign bus.BUSY  = busy_q;
   assign bus.DONE  = done_q;
   assign bus.STATE = state_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: scoreboard bench; expected state entries are queued by the stimulus
// and checked by a monitor each time STATE changes, with a behavioural counter driving Q.
module tb_count_sequencer;
   localparam int HOLD = 4;
   typedef struct {
      logic [2:0] st;
      logic       u_d, m, p_c, busy, done;
      int         dur;
   } item_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] qv, qg, q_ld_v;
   logic       q_ld;
   int         div = 0;
   int         vecs = 0, fails = 0;
   int         qmax, qmin;
   logic       mon_en = 1'b0;
   item_t      exp_q[$];
   item_t      cur;
   logic [2:0] prev_st = 3'd0;
   int         cur_dur = -1, len = 0;
   count_sequencer_if #(.WIDTH(5)) ifc();
   count_sequencer #(
      .WIDTH(5), .HI_LIM(6), .LO_LIM(2), .HOLD_CYCLES(HOLD), .CYCLES(2)
   ) dut (
      .CLK50MHz(clk),
      .RST(rst_n),
      .bus(ifc)
   );
   always #10 clk = ~clk;
   assign ifc.Q = qv ^ qg;
   // behavioural counter: one step every 8 clocks while enabled
   always @(posedge clk) begin
      if (q_ld) begin
         qv  <= q_ld_v;
         div <= 0;
      end else if (ifc.P_C) begin
         if (div == 7) begin
            div <= 0;
            qv  <= ifc.U_D ? qv + 5'd1 : qv - 5'd1;
         end else div <= div + 1;
      end
   end
   task automatic chk(input string nm, input int act, input int req);
      vecs++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask
   task automatic push(input logic [2:0] st, input logic u, input logic mm, input logic p,
                       input logic b, input logic d, input int dur);
      item_t e;
      e.st = st; e.u_d = u; e.m = mm; e.p_c = p; e.busy = b; e.done = d; e.dur = dur;
      exp_q.push_back(e);
   endtask
   task automatic push_sweep();
      push(3'd1, 1, 1, 1, 1, 0, -1);
      push(3'd2, 1, 1, 0, 1, 0, HOLD);
      push(3'd3, 0, 0, 1, 1, 0, -1);
      push(3'd4, 0, 0, 0, 1, 0, HOLD);
   endtask
   always @(negedge clk) begin
      if (mon_en) begin
         if (ifc.STATE != prev_st) begin
            if (cur_dur >= 0) chk($sformatf("dur_st%0d", prev_st), len, cur_dur);
            if (exp_q.size() == 0) begin
               chk("unexpected_state", int'(ifc.STATE), int'(prev_st));
               cur_dur = -1;
            end else begin
               cur = exp_q.pop_front();
               chk("state", int'(ifc.STATE), int'(cur.st));
               chk($sformatf("u_d_st%0d", cur.st), int'(ifc.U_D), int'(cur.u_d));
               chk($sformatf("m_st%0d", cur.st), int'(ifc.M), int'(cur.m));
               chk($sformatf("p_c_st%0d", cur.st), int'(ifc.P_C), int'(cur.p_c));
               chk($sformatf("busy_st%0d", cur.st), int'(ifc.BUSY), int'(cur.busy));
               chk($sformatf("done_st%0d", cur.st), int'(ifc.DONE), int'(cur.done));
               cur_dur = cur.dur;
            end
            prev_st = ifc.STATE;
            len = 1;
         end else len++;
      end
   end
   task automatic set_q(input logic [4:0] v);
      @(negedge clk);
      q_ld_v = v;
      q_ld = 1'b1;
      @(negedge clk);
      q_ld = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic pulse_start();
      @(negedge clk);
      ifc.START = 1'b1;
      repeat (4) @(negedge clk);
      ifc.START = 1'b0;
   endtask
   task automatic wait_state(input int s, input int lim);
      int n = 0;
      qmax = 0;
      qmin = 31;
      while (int'(ifc.STATE) != s && n < lim) begin
         @(negedge clk);
         n++;
         if (ifc.STATE inside {3'd1, 3'd2} && int'(ifc.Q) > qmax) qmax = int'(ifc.Q);
         if (ifc.STATE inside {3'd3, 3'd4} && int'(ifc.Q) < qmin) qmin = int'(ifc.Q);
      end
      if (int'(ifc.STATE) != s) chk($sformatf("wait_st%0d", s), int'(ifc.STATE), s);
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_u_d"}, int'(ifc.U_D), 1);
      chk({tag, "_m"}, int'(ifc.M), 0);
      chk({tag, "_p_c"}, int'(ifc.P_C), 0);
      chk({tag, "_busy"}, int'(ifc.BUSY), 0);
      chk({tag, "_done"}, int'(ifc.DONE), 0);
      chk({tag, "_state"}, int'(ifc.STATE), 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, %0d vectors applied", vecs);
      $fatal(1);
   end
   initial begin
      ifc.START = 1'b0;
      ifc.STOP = 1'b0;
      qg = '0;
      q_ld = 1'b1;
      q_ld_v = 5'($urandom_range(0, 31));
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         ifc.START = 1'($urandom);
         ifc.STOP = 1'($urandom);
         q_ld_v = 5'($urandom);
      end
      chk_reset_vals("rst");
      ifc.START = 1'b0;
      ifc.STOP = 1'b0;
      q_ld_v = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q_ld = 1'b0;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;
      // full two-sweep run from Q=0
      set_q(5'd0);
      push_sweep();
      push_sweep();
      push(3'd5, 0, 0, 0, 0, 1, -1);
      @(negedge clk);
      ifc.START = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("start_lat_early", int'(ifc.STATE), 0);
      @(posedge clk);
      #1 chk("start_lat_state", int'(ifc.STATE), 1);
      chk("start_lat_pc", int'(ifc.P_C), 1);
      @(negedge clk);
      ifc.START = 1'b0;
      wait_state(5, 2000);
      chk("q_peak_6_7", int'(qmax >= 6 && qmax <= 7), 1);
      chk("q_dip_1_2", int'(qmin >= 1 && qmin <= 2), 1);
      // start with Q already above the high limit
      set_q(5'd10);
      push(3'd1, 1, 1, 1, 1, 0, 1);
      push(3'd2, 1, 1, 0, 1, 0, HOLD);
      push(3'd3, 0, 0, 1, 1, 0, -1);
      pulse_start();
      wait_state(3, 200);
      repeat (10) @(negedge clk);
      // abort during the down leg
      push(3'd0, 0, 0, 0, 0, 0, -1);
      ifc.STOP = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("stop_lat_early", int'(ifc.STATE), 3);
      @(posedge clk);
      #1 chk("stop_lat_state", int'(ifc.STATE), 0);
      chk("stop_lat_pc", int'(ifc.P_C), 0);
      @(negedge clk);
      ifc.STOP = 1'b0;
      repeat (3) @(negedge clk);
      // restart gives two full sweeps; a start edge during HOLD_HI is ignored
      set_q(5'd0);
      push_sweep();
      push_sweep();
      push(3'd5, 0, 0, 0, 0, 1, -1);
      pulse_start();
      wait_state(2, 500);
      ifc.START = 1'b1;
      repeat (4) @(negedge clk);
      ifc.START = 1'b0;
      wait_state(5, 2000);
      push(3'd0, 0, 0, 0, 0, 0, -1);
      @(negedge clk);
      ifc.STOP = 1'b1;
      repeat (4) @(negedge clk);
      ifc.STOP = 1'b0;
      wait_state(0, 20);
      // simultaneous START and STOP edges in IDLE
      @(negedge clk);
      ifc.START = 1'b1;
      ifc.STOP = 1'b1;
      repeat (10) @(negedge clk);
      chk("both_idle", int'(ifc.STATE), 0);
      ifc.START = 1'b0;
      ifc.STOP = 1'b0;
      repeat (3) @(negedge clk);
      // one-cycle glitch on Q during RUN_UP must not end the leg
      set_q(5'd0);
      push(3'd1, 1, 1, 1, 1, 0, -1);
      pulse_start();
      wait_state(1, 20);
      repeat (2) @(negedge clk);
      qg = 5'd8;
      @(negedge clk);
      qg = '0;
      repeat (6) @(negedge clk);
      chk("glitch_state", int'(ifc.STATE), 1);
      // reset mid-run
      push(3'd0, 1, 0, 0, 0, 0, -1);
      rst_n = 1'b0;
      @(posedge clk);
      #1 chk_reset_vals("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule

// File: doc/count_sequencer.md
# count_sequencer

Autonomous controller for the board's frequency-divider/up-down-counter datapath. Instead of driving the counter's direction (U_D), speed select (M) and pause/continue (P_C) straight from slide switches, this block runs a programmed sweep: fast count up to a high limit, hold, slow count down to a low limit, hold, repeated a set number of times. It monitors the counter output Q to decide when each leg ends. It sits at top level between the START/STOP buttons and the datapath control pins.

## Interface
- WIDTH, 5: width of monitored count Q
- HI_LIM, 24: up-leg terminates when Q ≥ HI_LIM
- LO_LIM, 3: down-leg terminates when Q ≤ LO_LIM
- HOLD_CYCLES, 50_000_000: hold duration in CLK50MHz cycles (≥1)
- CYCLES, 4: number of up/down sweeps; 0 = loop forever

- CLK50MHz  in  1  system clock; the only clock
- RST  in  1  synchronous, active-low reset
- START  in  1  raw button level; rising edge starts a run
- STOP  in  1  raw button level; rising edge aborts to IDLE
- Q  in  WIDTH  counter output (asynchronous to CLK50MHz: counter runs on divided clock)
- U_D  out  1  counter direction, 1 = up
- M  out  1  divider speed select, 1 = fast
- P_C  out  1  counter enable, 1 = count, 0 = pause
- BUSY  out  1  high in RUN_UP, HOLD_HI, RUN_DN, HOLD_LO
- DONE  out  1  high in DONE state
- STATE  out  3  current state encoding

## Operation
- Inputs: START, STOP each pass a 2-flop synchronizer, then a rising-edge detector (one-cycle pulse). No debounce (external).
- Q: 2-flop synchronizer per bit; the sampled value qs updates only when two consecutive synchronized samples agree (glitch filter for multi-bit crossing).
- States (encoding): IDLE 0, RUN_UP 1, HOLD_HI 2, RUN_DN 3, HOLD_LO 4, DONE 5; 6/7 illegal → IDLE.
- IDLE: P_C=0. start pulse → RUN_UP, sweep counter cyc=0.
- RUN_UP: U_D=1, M=1, P_C=1. qs ≥ HI_LIM → HOLD_HI (checked every cycle, including the first cycle in the state).
- HOLD_HI: P_C=0, U_D/M hold previous values; hold timer counts HOLD_CYCLES cycles, then → RUN_DN.
- RUN_DN: U_D=0, M=0, P_C=1. qs ≤ LO_LIM → HOLD_LO.
- HOLD_LO: P_C=0; after HOLD_CYCLES: if CYCLES≠0 and cyc+1 == CYCLES → DONE, else cyc++ and → RUN_UP.
- DONE: P_C=0, DONE=1 until a start pulse (→ RUN_UP, cyc=0) or a stop pulse (→ IDLE).
- stop pulse in any state → IDLE next cycle. STOP and START in the same cycle: STOP wins.
- start pulse while BUSY: ignored.
- Hold timer: cleared on every state entry. Width = clog2(HOLD_CYCLES)+1. cyc width = clog2(CYCLES)+1.
- ≥/≤ compares tolerate overshoot by one count caused by sync latency. Counter wrap (31→0) is not detected specially. HI_LIM ≤ LO_LIM is unsupported.

## Timing
- All outputs registered. Reset values: U_D=1, M=0, P_C=0, BUSY=0, DONE=0, STATE=0.
- Reset has priority over all events. Asserting reset mid-run forces the reset values on the next edge. Timers, cyc and synchronizers clear.
- START edge → STATE=1 / P_C=1: 3 cycles after the raw rise (2 sync + 1 edge/register).
- Q change → qs update: 3 cycles (2 sync + 1 agreement). Limit hit → state change + P_C=0: 1 further cycle.
- Hold: P_C low for exactly HOLD_CYCLES cycles between leaving RUN_x and P_C=1 in the next run state.
- STOP edge → P_C=0, STATE=0: 3 cycles after the raw rise.

## Test plan
Bench params: HI_LIM=6, LO_LIM=2, HOLD_CYCLES=4, CYCLES=2. Q is driven by a behavioural counter stepping every 8 clocks while P_C=1, per U_D.
- Reset: hold RST=0 for 3 cycles with random inputs → U_D=1, M=0, P_C=0, BUSY=0, DONE=0, STATE=0.
- Full run from Q=0: pulse START → STATE sequence 1,2,3,4,1,2,3,4,5. Q peaks at 6 or 7 and dips to 2 or 1. Each hold shows P_C=0 for exactly 4 cycles. DONE=1 at end, BUSY=0.
- Entry above limit: Q=10, pulse START → RUN_UP for exactly 1 cycle, then HOLD_HI. P_C is high for 1 cycle only.
- Abort: STOP pulse during RUN_DN → STATE=0, P_C=0 3 cycles after the rise. A later START restarts with cyc=0 (two full sweeps).
- Simultaneous START+STOP rising edges in IDLE → stays IDLE. START edge during HOLD_HI → ignored, sequence unchanged.
- Glitch filter: Q toggles a bit for 1 cycle while in RUN_UP → qs unchanged, no state change. Mid-run RST=0 → reset values next edge.
